// File: rtl/alu_seq_pkg.sv
// Shared types and ALU select encodings for the multi-byte ALU sequencer.
// Both the sequencer and its opcode encoder import this package.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOT = 3'd4
    } op_t;

    // ALU_X bits: bit0 NOT select, bit1 logic unit, bit2 sub/or, bit3 unused.
    localparam logic [3:0] X_ADD = 4'b0000;
    localparam logic [3:0] X_SUB = 4'b0100;
    localparam logic [3:0] X_AND = 4'b0010;
    localparam logic [3:0] X_OR  = 4'b0110;
    localparam logic [3:0] X_NOT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_encode.sv
// Maps a requester opcode to the ALU select code, a legality flag and
// whether the operation chains carry/borrow between byte slices.
module alu_op_encode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op_i,
    output logic [3:0] alu_x_o,
    output logic       legal_o,
    output logic       uses_carry_o
);

    always_comb begin
        alu_x_o      = X_ADD;
        legal_o      = 1'b0;
        uses_carry_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_x_o      = X_ADD;
                legal_o      = 1'b1;
                uses_carry_o = 1'b1;
            end
            OP_SUB: begin
                alu_x_o      = X_SUB;
                legal_o      = 1'b1;
                uses_carry_o = 1'b1;
            end
            OP_AND: begin
                alu_x_o = X_AND;
                legal_o = 1'b1;
            end
            OP_OR: begin
                alu_x_o = X_OR;
                legal_o = 1'b1;
            end
            OP_NOT: begin
                alu_x_o = X_NOT;
                legal_o = 1'b1;
            end
            default: begin
                alu_x_o      = X_ADD;
                legal_o      = 1'b0;
                uses_carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Issues one NBYTES-wide operation to an 8-bit combinational ALU, one byte
// slice per clock LSB first, chaining carry/borrow and assembling RESULT.
//
// Handshake: START is sampled on a rising edge only while BUSY is low (IDLE or
// FIN); an accepted legal START gives BUSY for NBYTES cycles followed by a
// one-cycle DONE, an illegal OP gives DONE with ERR on the next cycle.
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [2:0]            OP,
    input  logic                  CIN,
    input  logic [8*NBYTES-1:0]   OPA,
    input  logic [8*NBYTES-1:0]   OPB,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [8*NBYTES-1:0]   RESULT,
    output logic                  CARRY_OUT,
    output logic                  ERR,
    output logic [7:0]            ALU_A,
    output logic [7:0]            ALU_B,
    output logic [3:0]            ALU_X,
    output logic                  ALU_CIN,
    input  logic [7:0]            ALU_S,
    input  logic                  ALU_COUT,
    output logic [1:0]            DBG_STATE
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [8*NBYTES-1:0]   a_q;
    logic [8*NBYTES-1:0]   b_q;
    logic [3:0]            x_q;
    logic                  carry_en_q;
    logic                  carry_q;
    logic [8*NBYTES-1:0]   result_q;
    logic                  carry_out_q;
    logic                  err_q;
    logic                  done_q;

    logic [3:0]            enc_x;
    logic                  enc_legal;
    logic                  enc_uses_carry;
    logic [IDXW+2:0]       bit_base;
    logic                  running;

    alu_op_encode u_enc (
        .op_i         (OP),
        .alu_x_o      (enc_x),
        .legal_o      (enc_legal),
        .uses_carry_o (enc_uses_carry)
    );

    assign bit_base = {idx_q, 3'b000};
    assign running  = (state_q == RUN);

    // ALU drive is combinational from registered state so the whole slice
    // round trip completes in the same cycle; outside RUN everything is 0.
    assign ALU_A   = running ? a_q[bit_base +: 8] : 8'h00;
    assign ALU_B   = running ? b_q[bit_base +: 8] : 8'h00;
    assign ALU_X   = running ? x_q : X_ADD;
    assign ALU_CIN = running & carry_en_q & carry_q;

    assign BUSY      = running;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign CARRY_OUT = carry_out_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= X_ADD;
            carry_en_q  <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FIN: begin
                    if (START && enc_legal) begin
                        a_q         <= OPA;
                        b_q         <= OPB;
                        x_q         <= enc_x;
                        carry_en_q  <= enc_uses_carry;
                        // The initial carry/borrow seeds the chain register so
                        // slice 0 reads it like every later slice.
                        carry_q     <= CIN & enc_uses_carry;
                        idx_q       <= '0;
                        result_q    <= '0;
                        carry_out_q <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= RUN;
                    end else if (START) begin
                        result_q    <= '0;
                        carry_out_q <= 1'b0;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    result_q[bit_base +: 8] <= ALU_S;
                    carry_q                 <= ALU_COUT;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        carry_out_q <= carry_en_q & ALU_COUT;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer (NBYTES=4) with a behavioural 8-bit
// ALU, a DONE-driven scoreboard and per-cycle ALU select checks.
module tb_alu_byte_sequencer;
    import alu_seq_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB + 2;

    logic            CLK;
    logic            RST_N;
    logic            START;
    logic [2:0]      OP;
    logic            CIN;
    logic [8*NB-1:0] OPA;
    logic [8*NB-1:0] OPB;
    logic            BUSY;
    logic            DONE;
    logic [8*NB-1:0] RESULT;
    logic            CARRY_OUT;
    logic            ERR;
    logic [7:0]      ALU_A;
    logic [7:0]      ALU_B;
    logic [3:0]      ALU_X;
    logic            ALU_CIN;
    logic [7:0]      ALU_S;
    logic            ALU_COUT;
    logic [1:0]      DBG_STATE;

    logic [W-1:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    alu_byte_sequencer #(.NBYTES(NB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .OP        (OP),
        .CIN       (CIN),
        .OPA       (OPA),
        .OPB       (OPB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .CARRY_OUT (CARRY_OUT),
        .ERR       (ERR),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_X     (ALU_X),
        .ALU_CIN   (ALU_CIN),
        .ALU_S     (ALU_S),
        .ALU_COUT  (ALU_COUT),
        .DBG_STATE (DBG_STATE)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference ALU; NOT reports a carry of 1 that the sequencer must discard.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (ALU_X)
            4'b0000: alu_t = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_CIN};
            4'b0100: alu_t = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'h00, ALU_CIN};
            4'b0010: alu_t = {1'b0, ALU_A & ALU_B};
            4'b0110: alu_t = {1'b0, ALU_A | ALU_B};
            4'b0001: alu_t = {1'b1, ~ALU_A};
            default: alu_t = 9'h000;
        endcase
        ALU_S    = alu_t[7:0];
        ALU_COUT = alu_t[8];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic x_legal(input logic [3:0] x);
        return (x == 4'b0000) || (x == 4'b0100) || (x == 4'b0010) ||
               (x == 4'b0110) || (x == 4'b0001);
    endfunction

    // Scoreboard monitor
    always @(negedge CLK) begin
        check("alu_x_legal", {63'd0, x_legal(ALU_X)}, 64'd1);
        if (!BUSY)
            check("idle_alu_zero", {49'd0, ALU_X, ALU_A, ALU_B, ALU_CIN}, 64'd0);
        if (DONE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("result", {32'd0, RESULT}, {32'd0, e[31:0]});
                check("carry_out", {63'd0, CARRY_OUT}, {63'd0, e[32]});
                check("err", {63'd0, ERR}, {63'd0, e[33]});
            end
        end
    end

    // Drivers
    task automatic run_op(input logic [2:0] op, input logic cin,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic ee,
                          input int exp_lat, input int poke_at, output int done_cyc);
        int lat;
        int busy_n;
        @(negedge CLK);
        START = 1'b1;
        OP    = op;
        CIN   = cin;
        OPA   = a;
        OPB   = b;
        exp_q.push_back({ee, ec, er});
        @(posedge CLK);
        #1;
        START = 1'b0;
        OPA   = $urandom;
        OPB   = $urandom;
        CIN   = 1'($urandom_range(0, 1));
        lat    = 0;
        busy_n = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_n++;
            if (lat == poke_at) begin
                START = 1'b1;
                OP    = 3'd1;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        START = 1'b0;
        done_cyc = cyc;
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int d0;
        int d1;
        int saw_done;
        RST_N = 1'b0;
        START = 1'b0;
        OP    = 3'd0;
        CIN   = 1'b0;
        OPA   = '0;
        OPB   = '0;
        #12;
        check("reset_outputs", {30'd0, BUSY, DONE, CARRY_OUT, ERR, RESULT},  64'd0);
        check("reset_alu", {49'd0, ALU_X, ALU_A, ALU_B, ALU_CIN}, 64'd0);
        #11 RST_N = 1'b1;
        idle_cycles(2);

        // ADD
        run_op(3'd0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd0, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);

        // SUB
        run_op(3'd1, 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd1, 1'b1, 32'h00000005, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);

        // Logic ops, CIN=1 must be ignored
        run_op(3'd2, 1'b1, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd3, 1'b1, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);
        run_op(3'd4, 1'b1, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);

        // Illegal ops, then a legal ADD clears ERR
        run_op(3'd5, 1'b0, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1'b1, 0, -1, d0);
        idle_cycles(1);
        check("err_held", {62'd0, ERR, DONE}, 64'd2);
        run_op(3'd7, 1'b1, 32'h1, 32'h2, 32'h00000000, 1'b0, 1'b1, 0, -1, d0);
        idle_cycles(1);
        run_op(3'd0, 1'b0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 4, -1, d0);
        idle_cycles(1);

        // START while busy is ignored; START in FIN is accepted back-to-back
        run_op(3'd0, 1'b0, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, 1'b0, 4, 2, d0);
        idle_cycles(1);
        run_op(3'd0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 4, -1, d0);
        run_op(3'd1, 1'b0, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 1'b0, 4, -1, d1);
        check("b2b_done_spacing", 64'(d1 - d0), 64'd5);
        idle_cycles(1);

        // Asynchronous reset mid-run at idx=2, no DONE afterwards
        @(negedge CLK);
        START = 1'b1;
        OP    = 3'd0;
        OPA   = 32'hFFFFFFFF;
        OPB   = 32'h00000001;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("async_reset_outputs", {30'd0, BUSY, DONE, CARRY_OUT, ERR, RESULT}, 64'd0);
        check("async_reset_alu", {49'd0, ALU_X, ALU_A, ALU_B, ALU_CIN}, 64'd0);
        #3 RST_N = 1'b1;
        saw_done = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (DONE) saw_done = 1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Multi-byte operation controller that drives the team's 8-bit combinational ALU (ADD/SUB/AND/OR/NOT, 4-bit select X, carry/borrow in and out).
- Accepts one NBYTES-wide operation from a requester, issues one ALU byte-slice per clock (LSB first), chains carry/borrow between slices, and assembles RESULT.
- It is the initiator side of the ALU interface: it drives ALU_A/ALU_B/ALU_X/ALU_CIN and captures ALU_S/ALU_COUT.

Parameters:
NBYTES, 4, operand width in bytes (range 1..16)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous, active-low reset
START  in  1  request; sampled only when not BUSY
OP  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT (A only), 5-7 illegal
CIN  in  1  initial carry (ADD) or borrow (SUB); ignored for other ops
OPA  in  8*NBYTES  operand A
OPB  in  8*NBYTES  operand B
BUSY  out  1  high while slices are being issued
DONE  out  1  single-cycle completion pulse
RESULT  out  8*NBYTES  assembled result; held until next accepted START
CARRY_OUT  out  1  final carry (ADD) or borrow (SUB); 0 for AND/OR/NOT
ERR  out  1  illegal OP flag; valid with DONE, held until next START
ALU_A  out  8  slice of A to ALU
ALU_B  out  8  slice of B to ALU
ALU_X  out  4  ALU select
ALU_CIN  out  1  ALU carry/borrow in
ALU_S  in  8  ALU result
ALU_COUT  in  1  ALU carry/borrow out

Behaviour:
- Clocking and reset: one clock, CLK. RST_N is asynchronous, active-low.
- Reset: all outputs 0. ALU_X is 4'b0000. FSM goes to IDLE, byte index to 0.
- Reset mid-operation: aborts immediately. No DONE is generated afterwards.
- ALU_X encoding (bit0 = NOT select, bit1 = logic, bit2 = sub/or, bit3 always 0):
  - ADD 0000, SUB 0100, AND 0010, OR 0110, NOT 0001.
  - ALU_X is never driven to any other value. In IDLE/DONE it is 0000, and ALU_A/ALU_B/ALU_CIN are 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE/FIN, START=1, legal OP: latch OPA, OPB, OP, CIN; idx<=0; go to RUN; clear ERR and CARRY_OUT.
  - IDLE/FIN, START=1, illegal OP: go to FIN with DONE=1, ERR=1, RESULT<=0, CARRY_OUT<=0. No ALU traffic.
  - RUN, each cycle:
    - Drive ALU_A=A[8*idx+:8], ALU_B=B[8*idx+:8], ALU_X=enc(OP).
    - ALU_CIN = latched CIN when idx==0, else carry_q. ALU_CIN is forced to 0 for AND/OR/NOT.
    - On the edge: RESULT[8*idx+:8]<=ALU_S; carry_q<=ALU_COUT; idx<=idx+1.
  - RUN, edge with idx==NBYTES-1: go to FIN. DONE<=1. CARRY_OUT<=carry for ADD/SUB, 0 otherwise (the ALU's COUT for NOT is discarded).
  - FIN: DONE high for exactly this one cycle, then IDLE unless a new START is accepted.
  - FIN + START: accepted (back-to-back). DONE still deasserts on the next cycle.
- Latency: START sampled at edge 0, DONE high in the cycle after edge NBYTES. Throughput is one operation per NBYTES+1 cycles.
- BUSY: 1 exactly while in RUN. START while BUSY is ignored, with no effect on the latched operands.
- The operand inputs may change after the START edge without affecting the result.
- ALU timing: the ALU is purely combinational. The full ALU path must close within one cycle, with no extra wait state.
- Width rules:
  - idx width is clog2(NBYTES), minimum 1.
  - SUB is A - B - CIN using ripple borrow; borrow out = 1 when the true result is negative.

Decomposition:
- Package alu_seq_pkg holds:
  - the OP enum (op_t: OP_ADD..OP_NOT);
  - the ALU_X localparams (X_ADD=4'b0000, X_SUB=4'b0100, X_AND=4'b0010, X_OR=4'b0110, X_NOT=4'b0001);
  - the FSM state enum (IDLE, RUN, FIN).
- One combinational sub-module, alu_op_encode: OP in; ALU_X, legal flag and uses_carry flag out. This makes the encoding checkable in isolation.

Test Plan:
- All scenarios use NBYTES=4, a behavioural reference ALU model, and a check on every cycle that ALU_X ∈ {0000,0100,0010,0110,0001}.
1. ADD 0x000000FF+0x00000001, CIN=0 -> RESULT 0x00000100, CARRY_OUT 0. DONE high 4 cycles after the START edge, BUSY high exactly 4 cycles. Then 0xFFFFFFFF+0x00000001 -> 0x00000000, CARRY_OUT 1.
2. SUB 0x00000100-0x00000001 -> 0x000000FF, CARRY_OUT 0. SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, CARRY_OUT 1. SUB 5-3 with CIN=1 -> 0x00000001.
3. AND 0xF0F01234 & 0x0FF0FF00 -> 0x00F01200. OR of the same operands -> 0xFFF0FF34. NOT A=0x12345678 -> 0xEDCBA987. CARRY_OUT 0 in all three cases.
4. OP=5 -> DONE one cycle after START, ERR 1, RESULT 0, BUSY never high. A following legal ADD clears ERR.
5. START pulsed again at idx=2 of a running ADD -> ignored, result unchanged. START asserted during the FIN cycle -> second operation accepted, and its DONE arrives 5 cycles after the first DONE.
6. RST_N low asynchronously mid-RUN (idx=2) -> BUSY, DONE, RESULT, ALU_* go to 0 without waiting for a clock edge. No DONE after RST_N is released.
